// File: rtl/adder_bus_master.sv
// -----------------------------------------------------------------------------
// adder_bus_master
//
// Initiator for the adder unit's RISC-V style memory-mapped port. Host
// commands enter a small valid/ready FIFO. A four-state FSM issues them one
// at a time as single-cycle registered read/write strobes. Read data comes
// back on a valid/ready response channel. Rising edges of spike_detected are
// counted in a saturating counter.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready          read response handshake
//   rsp_addr/rsp_data            read response payload
//   risc_v_read/risc_v_write     bus strobes to the adder unit
//   risc_v_addr/risc_v_data_in   bus address / write data (hold between ops)
//   risc_v_data_out              bus read data from the adder unit
//   spike_detected               spike flag from the adder unit
//   spike_count/spike_count_clr  saturating spike edge count / sync clear
//   busy                         FIFO non-empty or FSM not idle
//
// Optional feature (macro ADDER_MASTER_SPIKE_IRQ_EN)
//   Adds parameter SPIKE_IRQ_THRESH, output spike_irq and input
//   spike_irq_ack. spike_irq sets when spike_count reaches the threshold and
//   stays set until acknowledged.
// -----------------------------------------------------------------------------
module adder_bus_master #(
    parameter int ADDR_WIDTH      = 6,
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int RD_LATENCY      = 1,
    parameter int SPIKE_CNT_WIDTH = 16
`ifdef ADDER_MASTER_SPIKE_IRQ_EN
    ,
    parameter int SPIKE_IRQ_THRESH = 8
`endif
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_WIDTH-1:0]      cmd_addr,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ADDR_WIDTH-1:0]      rsp_addr,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic                       risc_v_read,
    output logic                       risc_v_write,
    output logic [ADDR_WIDTH-1:0]      risc_v_addr,
    output logic [DATA_WIDTH-1:0]      risc_v_data_in,
    input  logic [DATA_WIDTH-1:0]      risc_v_data_out,
    input  logic                       spike_detected,
    output logic [SPIKE_CNT_WIDTH-1:0] spike_count,
    input  logic                       spike_count_clr,
`ifdef ADDER_MASTER_SPIKE_IRQ_EN
    output logic                       spike_irq,
    input  logic                       spike_irq_ack,
`endif
    output logic                       busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    localparam logic [PTR_W:0]           PTR_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [SPIKE_CNT_WIDTH-1:0] CNT_ONE  = {{(SPIKE_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SPIKE_CNT_WIDTH-1:0] CNT_MAX  = {SPIKE_CNT_WIDTH{1'b1}};
    localparam logic [2:0]               RD_LAT_L = 3'(RD_LATENCY);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    // ---------------------------------------------------------------- FIFO
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               ready_en_q;
    logic               fifo_empty, fifo_full;
    logic               push, pop;
    logic               head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    // The extra MSB distinguishes full (MSBs differ) from empty (all equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // ready_en_q keeps cmd_ready low throughout reset and releases it on the
    // first clock after reset_n deasserts.
    assign cmd_ready = ready_en_q && !fifo_full;
    assign push      = cmd_valid && cmd_ready;

    assign {head_write, head_addr, head_data} = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // ---------------------------------------------------------------- FSM
    logic [1:0]            state_q, state_d;
    logic                  hold_write_q, hold_write_d;
    logic                  rd_strobe_q, rd_strobe_d;
    logic                  wr_strobe_q, wr_strobe_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            wait_cnt_q, wait_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    always_comb begin
        state_d      = state_q;
        hold_write_d = hold_write_q;
        rd_strobe_d  = 1'b0;
        wr_strobe_d  = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_addr_d   = rsp_addr_q;
        rsp_data_d   = rsp_data_q;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                // The strobe and bus fields are registered here so they are
                // presented for exactly the ISSUE cycle.
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    hold_write_d = head_write;
                    addr_d       = head_addr;
                    if (head_write) begin
                        wdata_d = head_data;
                    end
                    wr_strobe_d  = head_write;
                    rd_strobe_d  = !head_write;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hold_write_q) begin
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = RD_LAT_L;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // Capturing on the count of 1 samples risc_v_data_out in the
                // cycle RD_LATENCY after the strobe cycle.
                if (wait_cnt_q <= 3'd1) begin
                    wait_cnt_d  = 3'd0;
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = addr_q;
                    rsp_data_d  = risc_v_data_out;
                    state_d     = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // ---------------------------------------------------------------- spikes
    logic                       spike_prev_q;
    logic [SPIKE_CNT_WIDTH-1:0] spike_count_q, spike_count_d;
    logic                       spike_edge;

    assign spike_edge = spike_detected && !spike_prev_q;

    always_comb begin
        spike_count_d = spike_count_q;
        if (spike_count_clr) begin
            spike_count_d = '0;
        end else if (spike_edge && (spike_count_q != CNT_MAX)) begin
            spike_count_d = spike_count_q + CNT_ONE;
        end
    end

`ifdef ADDER_MASTER_SPIKE_IRQ_EN
    localparam logic [SPIKE_CNT_WIDTH-1:0] IRQ_THRESH_L = SPIKE_IRQ_THRESH[SPIKE_CNT_WIDTH-1:0];

    logic spike_irq_q, spike_irq_d;

    // Setting is ordered after the ack so a crossing in the ack cycle wins.
    always_comb begin
        spike_irq_d = spike_irq_q;
        if (spike_irq_ack) begin
            spike_irq_d = 1'b0;
        end
        if ((spike_count_d == IRQ_THRESH_L) && (spike_count_q != IRQ_THRESH_L)) begin
            spike_irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            spike_irq_q <= 1'b0;
        end else begin
            spike_irq_q <= spike_irq_d;
        end
    end

    assign spike_irq = spike_irq_q;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ready_en_q    <= 1'b0;
            state_q       <= S_IDLE;
            hold_write_q  <= 1'b0;
            rd_strobe_q   <= 1'b0;
            wr_strobe_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wait_cnt_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            spike_prev_q  <= 1'b0;
            spike_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ready_en_q    <= 1'b1;
            state_q       <= state_d;
            hold_write_q  <= hold_write_d;
            rd_strobe_q   <= rd_strobe_d;
            wr_strobe_q   <= wr_strobe_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_data_q    <= rsp_data_d;
            spike_prev_q  <= spike_detected;
            spike_count_q <= spike_count_d;
        end
    end

    assign risc_v_read    = rd_strobe_q;
    assign risc_v_write   = wr_strobe_q;
    assign risc_v_addr    = addr_q;
    assign risc_v_data_in = wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_addr       = rsp_addr_q;
    assign rsp_data       = rsp_data_q;
    assign spike_count    = spike_count_q;
    assign busy           = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_adder_bus_master.sv
// -----------------------------------------------------------------------------
// tb_adder_bus_master
//
// Directed bench for adder_bus_master with default parameters (RD_LATENCY=1,
// FIFO_DEPTH=4). A small memory model stands in for the adder unit and
// returns read data one cycle after the read strobe. Every strobe is logged
// with the clock edge that ended it. When ADDER_MASTER_SPIKE_IRQ_EN is
// defined the DUT is built with SPIKE_IRQ_THRESH=2 and the interrupt is
// exercised as well.
// -----------------------------------------------------------------------------
module tb_adder_bus_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [5:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [5:0]  rsp_addr;
    logic [15:0] rsp_data;
    logic        risc_v_read;
    logic        risc_v_write;
    logic [5:0]  risc_v_addr;
    logic [15:0] risc_v_data_in;
    logic [15:0] risc_v_data_out;
    logic        spike_detected;
    logic [15:0] spike_count;
    logic        spike_count_clr;
    logic        busy;
`ifdef ADDER_MASTER_SPIKE_IRQ_EN
    logic        spike_irq;
    logic        spike_irq_ack;
`endif

    adder_bus_master #(
        .ADDR_WIDTH      (6),
        .DATA_WIDTH      (16),
        .FIFO_DEPTH      (4),
        .RD_LATENCY      (1),
        .SPIKE_CNT_WIDTH (16)
`ifdef ADDER_MASTER_SPIKE_IRQ_EN
        ,
        .SPIKE_IRQ_THRESH(2)
`endif
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_addr        (rsp_addr),
        .rsp_data        (rsp_data),
        .risc_v_read     (risc_v_read),
        .risc_v_write    (risc_v_write),
        .risc_v_addr     (risc_v_addr),
        .risc_v_data_in  (risc_v_data_in),
        .risc_v_data_out (risc_v_data_out),
        .spike_detected  (spike_detected),
        .spike_count     (spike_count),
        .spike_count_clr (spike_count_clr),
`ifdef ADDER_MASTER_SPIKE_IRQ_EN
        .spike_irq       (spike_irq),
        .spike_irq_ack   (spike_irq_ack),
`endif
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------ adder unit model + log
    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [15:0] data;
        int          cyc;
    } bus_ev_t;

    bus_ev_t     bus_log[$];
    logic [15:0] tb_mem [64];
    int          cyc = 0;

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = 16'h0;
        risc_v_data_out = 16'h0;
    end

    always @(posedge clk) begin
        if (risc_v_read && risc_v_write) check("strobe_excl", 32'd1, 32'd0);
        if (risc_v_read || risc_v_write) begin
            bus_log.push_back('{risc_v_write, risc_v_addr, risc_v_data_in, cyc});
            $display("[TB] bus %s addr=%0d data=0x%04h edge=%0d",
                     risc_v_write ? "WR" : "RD", risc_v_addr,
                     risc_v_write ? risc_v_data_in : tb_mem[risc_v_addr], cyc);
        end
        if (risc_v_write) tb_mem[risc_v_addr] <= risc_v_data_in;
        if (risc_v_read)  risc_v_data_out     <= tb_mem[risc_v_addr];
        cyc <= cyc + 1;
    end

    // ------------------------------------------------ helpers
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the push edge.
    task automatic push_cmd(input logic wr, input logic [5:0] addr, input logic [15:0] data);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("push_timeout", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        $display("[TB] cmd %s addr=%0d data=0x%04h", wr ? "WR" : "RD", addr, data);
    endtask

    task automatic wait_log(input int n);
        int guard = 0;
        while (bus_log.size() < n && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("log_count", 32'(bus_log.size()), 32'(n));
    endtask

    task automatic wait_rsp(output int seen_cyc);
        int guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rsp_arrive", 32'(rsp_valid), 32'd1);
        seen_cyc = cyc;
    endtask

    task automatic spike_run(input logic lvl, input int n);
        spike_detected = lvl;
        step(n);
    endtask

    // ------------------------------------------------ stimulus
    initial begin
        int rsp_cyc;
        int base;

        reset_n         = 1'b0;
        cmd_valid       = 1'b0;
        cmd_write       = 1'b0;
        cmd_addr        = '0;
        cmd_wdata       = '0;
        rsp_ready       = 1'b0;
        spike_detected  = 1'b0;
        spike_count_clr = 1'b0;
`ifdef ADDER_MASTER_SPIKE_IRQ_EN
        spike_irq_ack   = 1'b0;
`endif

        // ---- reset state
        step(3);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_strobes", {30'd0, risc_v_read, risc_v_write}, 32'd0);
        check("rst_spike_count", 32'(spike_count), 32'd0);
`ifdef ADDER_MASTER_SPIKE_IRQ_EN
        check("rst_spike_irq", 32'(spike_irq), 32'd0);
`endif
        reset_n = 1'b1;
        step(1);
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // ---- single write
        push_cmd(1'b1, 6'd5, 16'h0003);
        wait_log(1);
        step(4);
        check("wr_one_strobe", 32'(bus_log.size()), 32'd1);
        check("wr_kind", 32'(bus_log[0].wr), 32'd1);
        check("wr_addr", 32'(bus_log[0].addr), 32'd5);
        check("wr_data", 32'(bus_log[0].data), 32'h0003);
        check("wr_no_rsp", 32'(rsp_valid), 32'd0);
        check("wr_idle", 32'(busy), 32'd0);

        // ---- read with a held response
        push_cmd(1'b0, 6'd5, 16'h0000);
        wait_rsp(rsp_cyc);
        check("rd_strobe_count", 32'(bus_log.size()), 32'd2);
        check("rd_kind", 32'(bus_log[1].wr), 32'd0);
        check("rd_bus_addr", 32'(bus_log[1].addr), 32'd5);
        check("rd_latency", 32'(rsp_cyc - bus_log[1].cyc), 32'd2);
        check("rd_rsp_addr", 32'(rsp_addr), 32'd5);
        check("rd_rsp_data", 32'(rsp_data), 32'h0003);
        push_cmd(1'b1, 6'd7, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_addr", 32'(rsp_addr), 32'd5);
            check("hold_data", 32'(rsp_data), 32'h0003);
            check("hold_no_strobe", 32'(bus_log.size()), 32'd2);
            step(1);
        end
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        check("rsp_cleared", 32'(rsp_valid), 32'd0);
        wait_log(3);
        check("wr7_addr", 32'(bus_log[2].addr), 32'd7);
        check("wr7_data", 32'(bus_log[2].data), 32'h1234);

        // ---- fill the FIFO while a response is stalled, then 5 writes drain
        push_cmd(1'b0, 6'd7, 16'h0000);
        wait_rsp(rsp_cyc);
        check("rd7_data", 32'(rsp_data), 32'h1234);
        check("rd7_addr", 32'(rsp_addr), 32'd7);
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 6'(10 + i), 16'(16'hA0 + i));
        check("full_ready_low", 32'(cmd_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        step(2);
        check("full_still_low", 32'(cmd_ready), 32'd0);
        check("full_no_strobe", 32'(bus_log.size()), 32'd4);
        rsp_ready = 1'b1;
        step(1);
        rsp_ready = 1'b0;
        push_cmd(1'b1, 6'd14, 16'h00A4);
        wait_log(9);
        check("b2b_busy_low", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("b2b_kind", 32'(bus_log[4 + i].wr), 32'd1);
            check("b2b_addr", 32'(bus_log[4 + i].addr), 32'(10 + i));
            check("b2b_data", 32'(bus_log[4 + i].data), 32'(16'hA0 + i));
            if (i > 0) check("b2b_spacing", 32'(bus_log[4 + i].cyc - bus_log[3 + i].cyc), 32'd2);
        end

        // ---- spike counting
        spike_run(1'b1, 4);
        spike_run(1'b0, 2);
        spike_run(1'b1, 1);
        spike_run(1'b0, 1);
        spike_run(1'b1, 1);
        spike_run(1'b0, 1);
        check("spike_count3", 32'(spike_count), 32'd3);
        spike_detected  = 1'b1;
        spike_count_clr = 1'b1;
        step(1);
        spike_count_clr = 1'b0;
        check("spike_clr_wins", 32'(spike_count), 32'd0);
        step(1);
        check("spike_level_once", 32'(spike_count), 32'd0);
        spike_run(1'b0, 1);

        // ---- reset during RD_WAIT discards the FIFO and the pending read
        base = bus_log.size();
        push_cmd(1'b0, 6'd5, 16'h0000);
        push_cmd(1'b1, 6'd20, 16'h5555);
        push_cmd(1'b1, 6'd21, 16'h6666);
        check("rw_read_issued", 32'(bus_log.size()), 32'(base + 1));
        check("rw_no_rsp_yet", 32'(rsp_valid), 32'd0);
        check("rw_fifo_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_strobes", {30'd0, risc_v_read, risc_v_write}, 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("arst_addr", 32'(risc_v_addr), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(1);
        check("arst_ready_back", 32'(cmd_ready), 32'd1);
        step(6);
        check("arst_fifo_flushed", 32'(bus_log.size()), 32'(base + 1));
        check("arst_no_rsp", 32'(rsp_valid), 32'd0);
        push_cmd(1'b1, 6'd9, 16'hBEEF);
        wait_log(base + 2);
        check("arst_next_addr", 32'(bus_log[base + 1].addr), 32'd9);
        check("arst_next_data", 32'(bus_log[base + 1].data), 32'hBEEF);

`ifdef ADDER_MASTER_SPIKE_IRQ_EN
        // ---- spike interrupt at threshold 2
        check("irq_start_low", 32'(spike_irq), 32'd0);
        spike_run(1'b1, 1);
        spike_run(1'b0, 1);
        check("irq_one_edge", 32'(spike_irq), 32'd0);
        spike_run(1'b1, 1);
        check("irq_set", 32'(spike_irq), 32'd1);
        spike_run(1'b0, 1);
        spike_count_clr = 1'b1;
        step(1);
        spike_count_clr = 1'b0;
        check("irq_survives_clr", 32'(spike_irq), 32'd1);
        spike_irq_ack = 1'b1;
        step(1);
        spike_irq_ack = 1'b0;
        check("irq_acked", 32'(spike_irq), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_bus_master.md
Name: adder_bus_master

Overview:
- Initiator side of the adder unit's RISC-V memory-mapped port: drives risc_v_read/risc_v_write/risc_v_addr/risc_v_data_in and captures risc_v_data_out.
- Accepts host commands through a valid/ready command FIFO and issues one bus transaction at a time.
- Returns read data on a valid/ready response channel and counts spike_detected events from the adder unit.
- Sits between the control processor/sequencer and adder_unit.

Parameters:
- ADDR_WIDTH, 6, adder unit address width.
- DATA_WIDTH, 16, bus data width.
- FIFO_DEPTH, 4, command FIFO entries; must be a power of two and at least 2.
- RD_LATENCY, 1, cycles from the read-strobe cycle to the cycle in which risc_v_data_out is valid (1..7).
- SPIKE_CNT_WIDTH, 16, spike counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  host accepts response.
- rsp_addr  out  ADDR_WIDTH  address of the read.
- rsp_data  out  DATA_WIDTH  read data.
- risc_v_read  out  1  read strobe to adder unit.
- risc_v_write  out  1  write strobe to adder unit.
- risc_v_addr  out  ADDR_WIDTH  bus address.
- risc_v_data_in  out  DATA_WIDTH  bus write data.
- risc_v_data_out  in  DATA_WIDTH  bus read data.
- spike_detected  in  1  spike flag from adder unit.
- spike_count  out  SPIKE_CNT_WIDTH  saturating count of spike rising edges.
- spike_count_clr  in  1  synchronous clear of spike_count.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, FIFO empty, FSM in IDLE, spike edge register 0, cmd_ready 0 while in reset. cmd_ready = !full starting the first cycle after reset is released.
- FIFO
  - A push occurs when cmd_valid && cmd_ready.
  - Full is detected with an extra pointer bit; pointers wrap modulo FIFO_DEPTH.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - A push to a full FIFO is impossible because cmd_ready is 0.
- FSM states: IDLE, ISSUE, RD_WAIT, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into a holding register and go to ISSUE. A command pushed into an empty FIFO is popped no earlier than the next cycle.
  - ISSUE: drive exactly one cycle of registered strobe with risc_v_addr and, for writes, risc_v_data_in.
    - Write: risc_v_write=1, then back to IDLE.
    - Read: risc_v_read=1, load the wait counter with RD_LATENCY, go to RD_WAIT.
  - RD_WAIT: decrement the counter. When the counter reaches 0 (exactly RD_LATENCY cycles after the strobe cycle), capture risc_v_data_out into rsp_data, set rsp_valid=1, go to RESP.
  - RESP: hold rsp_valid, rsp_addr and rsp_data stable until rsp_ready is high, then clear rsp_valid and return to IDLE. No new command issues while in RESP.
- Strobes are never both high. Both strobes are 0 in every state except ISSUE. risc_v_addr and risc_v_data_in hold their last value between transactions.
- Throughput:
  - Back-to-back writes: one strobe every 2 cycles.
  - Read: at least RD_LATENCY+3 cycles per read.
- Spike counting
  - Counter increments on a 0->1 transition of spike_detected (registered previous value); a level held high counts once.
  - Saturates at all-ones.
  - spike_count_clr has priority over an increment in the same cycle.
- Reset mid-transaction: strobes drop immediately; the FIFO contents and any pending response are discarded.

Optional Feature:
- Macro ADDER_MASTER_SPIKE_IRQ_EN.
- When defined:
  - Adds parameter SPIKE_IRQ_THRESH (default 8), output spike_irq and input spike_irq_ack.
  - spike_irq goes high (registered) on the cycle spike_count becomes equal to SPIKE_IRQ_THRESH, and stays high until spike_irq_ack.
  - Ack and a new threshold crossing in the same cycle leave spike_irq high.
  - spike_count_clr does not clear spike_irq.
  - Reset value of spike_irq is 0.
- When undefined: none of these ports or parameters exist, and the block's behaviour is otherwise identical.

Test Plan:
- Write 0x0003 to address 5 -> exactly one cycle of risc_v_write=1 with risc_v_addr=5 and risc_v_data_in=0x0003; no rsp_valid.
- Read address 5 with RD_LATENCY=1 and a model returning 0x0003 one cycle after the strobe -> rsp_valid=1, rsp_addr=5, rsp_data=0x0003. With rsp_ready held low for 3 cycles, the response stays stable and no further strobes occur.
- Push 5 writes back-to-back with FIFO_DEPTH=4 -> cmd_ready drops when the FIFO is full. All 5 strobes appear in order at 2-cycle spacing, and busy falls after the last one.
- spike_detected high for 4 cycles, then 2 separate 1-cycle pulses -> spike_count=3. Asserting spike_count_clr on the same cycle as a new edge -> spike_count=0.
- Assert reset_n low during RD_WAIT -> strobes and rsp_valid are 0 asynchronously, the FIFO is empty after reset, and the next command executes normally.
- With ADDER_MASTER_SPIKE_IRQ_EN and SPIKE_IRQ_THRESH=2: 2 spike edges -> spike_irq=1; after spike_irq_ack it returns to 0.
